// File: rtl/dma_bus_master_pkg.sv
// Shared definitions for the DMA copy engine: register map, CTRL/STATUS bits,
// FSM encoding and the small command/status bundles passed between blocks.
package dma_bus_master_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_CLEAR   = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RUN,
    ST_DRAIN
  } dma_state_e;

  // Field order matches the CTRL / STATUS bit indices (bit0 first from the LSB).
  typedef struct packed {
    logic clear;
    logic abort;
    logic start;
  } dma_cmd_t;

  typedef struct packed {
    logic aborted;
    logic done;
    logic busy;
  } dma_status_t;

  function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:2] == base[15:2];
  endfunction

endpackage

// File: rtl/dma_regs.sv
// Responder side of the DMA engine: window decode, registered readback and
// CTRL command pulses. Parameter registers themselves live in the top.
module dma_regs
  import dma_bus_master_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h8500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] read_addr,
  output logic [15:0] read_data,
  input  logic [15:0] write_addr,
  input  logic [2:0]  ctrl_data,
  input  logic        write_strobe,
  input  logic [15:0] src,
  input  logic [15:0] dst,
  input  logic [15:0] len,
  input  dma_status_t status,
  output logic        wr_src,
  output logic        wr_dst,
  output logic        wr_len,
  output dma_cmd_t    cmd
);

  logic        wr_hit;
  logic        ctrl_hit;
  logic [15:0] rd_mux;

  assign wr_hit   = write_strobe && in_window(write_addr, BASE_ADDR);
  assign ctrl_hit = wr_hit && (write_addr[1:0] == REG_CTRL);

  // Parameter registers are frozen while a transfer owns them.
  assign wr_src = wr_hit && !status.busy && (write_addr[1:0] == REG_SRC);
  assign wr_dst = wr_hit && !status.busy && (write_addr[1:0] == REG_DST);
  assign wr_len = wr_hit && !status.busy && (write_addr[1:0] == REG_LEN);

  assign cmd.start = ctrl_hit && ctrl_data[CTRL_START];
  assign cmd.abort = ctrl_hit && ctrl_data[CTRL_ABORT];
  assign cmd.clear = ctrl_hit && ctrl_data[CTRL_CLEAR];

  always_comb begin
    rd_mux = '0;
    case (read_addr[1:0])
      REG_SRC: rd_mux = src;
      REG_DST: rd_mux = dst;
      REG_LEN: rd_mux = len;
      default: rd_mux = {13'd0, status};
    endcase
  end

  // One-cycle read latency like RAM; zero when unselected so the bus can OR.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) read_data <= '0;
    else       read_data <= in_window(read_addr, BASE_ADDR) ? rd_mux : 16'd0;
  end

endmodule

// File: rtl/dma_bus_master.sv
// Memory-to-memory copy engine: programmed through a 4-word register window,
// then takes the bus and streams SRC->DST at one word per cycle.
module dma_bus_master
  import dma_bus_master_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h8500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] read_addr,
  output logic [15:0] read_data,
  input  logic [15:0] write_addr,
  input  logic [15:0] write_data,
  input  logic        write_strobe,
  output logic [15:0] m_read_addr,
  input  logic [15:0] m_read_data,
  output logic [15:0] m_write_addr,
  output logic [15:0] m_write_data,
  output logic        m_write_strobe,
  output logic        o_bus_req,
  input  logic        i_bus_grant,
  output logic        o_done
);

  dma_state_e  state, state_nxt;
  dma_status_t status;
  dma_cmd_t    cmd;

  logic [15:0] src, dst, len;
  logic        rd_vld, aborting, done_flag, aborted_flag;
  logic        wr_src, wr_dst, wr_len;
  logic        start_ok, issue, wr_fire, rollback, finish, done_evt, aborted_set;
  logic        moving;

  assign status = '{aborted: aborted_flag, done: done_flag, busy: (state != ST_IDLE)};

  dma_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .write_addr   (write_addr),
    .ctrl_data    (write_data[2:0]),
    .write_strobe (write_strobe),
    .src          (src),
    .dst          (dst),
    .len          (len),
    .status       (status),
    .wr_src       (wr_src),
    .wr_dst       (wr_dst),
    .wr_len       (wr_len),
    .cmd          (cmd)
  );

  assign moving   = (state == ST_RUN) || (state == ST_DRAIN);
  assign start_ok = (state == ST_IDLE) && cmd.start && !cmd.abort;
  assign issue    = (state == ST_RUN) && i_bus_grant && !cmd.abort;
  assign wr_fire  = moving && rd_vld && i_bus_grant;
  // Grant lost under an in-flight read: drop the word and un-advance SRC/LEN.
  assign rollback = moving && rd_vld && !i_bus_grant;
  assign finish   = (state == ST_DRAIN) && !(rollback && !aborting);

  assign done_evt    = (start_ok && len == 16'd0) || ((state == ST_REQ) && cmd.abort) || finish;
  assign aborted_set = ((state == ST_REQ) && cmd.abort) || (finish && aborting);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok && len != 16'd0) state_nxt = ST_REQ;
      ST_REQ:   if (cmd.abort) state_nxt = ST_IDLE;
                else if (i_bus_grant) state_nxt = ST_RUN;
      ST_RUN:   if (cmd.abort || (issue && len == 16'd1)) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = finish ? ST_IDLE : ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_bus_req      = (state != ST_IDLE);
    m_read_addr    = '0;
    m_write_addr   = '0;
    m_write_data   = '0;
    m_write_strobe = 1'b0;
    if (issue) m_read_addr = src;
    if (wr_fire) begin
      m_write_addr   = dst;
      m_write_data   = m_read_data;
      m_write_strobe = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      src          <= '0;
      dst          <= '0;
      len          <= '0;
      rd_vld       <= 1'b0;
      aborting     <= 1'b0;
      done_flag    <= 1'b0;
      aborted_flag <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      rd_vld <= issue;
      o_done <= done_evt;

      if (wr_src)        src <= write_data;
      else if (issue)    src <= src + 16'd1;
      else if (rollback) src <= src - 16'd1;

      if (wr_dst)       dst <= write_data;
      else if (wr_fire) dst <= dst + 16'd1;

      // LEN doubles as the remaining-word counter during a transfer.
      if (wr_len)        len <= write_data;
      else if (issue)    len <= len - 16'd1;
      else if (rollback) len <= len + 16'd1;

      if ((state == ST_RUN) && cmd.abort) aborting <= 1'b1;
      else if (state_nxt == ST_IDLE)      aborting <= 1'b0;

      if (cmd.clear || start_ok) begin
        done_flag    <= 1'b0;
        aborted_flag <= 1'b0;
      end
      if (done_evt)    done_flag    <= 1'b1;
      if (aborted_set) aborted_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_bus_master.sv
// Bench for dma_bus_master: RAM/grant models, a write scoreboard fed at start,
// and directed register-level scenarios.
module tb_dma_bus_master;

  localparam logic [15:0] BASE = 16'h8500;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] read_addr, read_data, write_addr, write_data;
  logic        write_strobe;
  logic [15:0] m_read_addr, m_read_data, m_write_addr, m_write_data;
  logic        m_write_strobe, o_bus_req, i_bus_grant, o_done;

  dma_bus_master #(.BASE_ADDR(BASE)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .read_addr      (read_addr),
    .read_data      (read_data),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .write_strobe   (write_strobe),
    .m_read_addr    (m_read_addr),
    .m_read_data    (m_read_data),
    .m_write_addr   (m_write_addr),
    .m_write_data   (m_write_data),
    .m_write_strobe (m_write_strobe),
    .o_bus_req      (o_bus_req),
    .i_bus_grant    (i_bus_grant),
    .o_done         (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int   n_vec = 0, n_err = 0;
  int   wr_cnt = 0, run_len = 0, max_run = 0, done_cnt = 0;
  int   gap_strobes = 0, rd_after_abort = 0;
  logic req_seen = 1'b0, abort_flag = 1'b0, gnt_hold = 1'b0;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Source regions are never written, so a read returns the fill pattern.
  always @(posedge i_clk) m_read_data <= pat(m_read_addr);

  // Core side: grant two cycles after the request appears, unless held off.
  initial begin
    int rc;
    rc = 0;
    i_bus_grant = 1'b0;
    forever begin
      @(posedge i_clk); #2;
      if (o_bus_req) rc++; else rc = 0;
      i_bus_grant = o_bus_req && (rc >= 2) && !gnt_hold;
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_bus_req) req_seen = 1'b1;
      if (o_done) done_cnt++;
      if (abort_flag && m_read_addr != 16'd0) rd_after_abort++;
      if (m_write_strobe) begin
        wr_cnt++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (!i_bus_grant) gap_strobes++;
        if (exp_q.size() == 0) chk("wr_unexpected", 16'(m_write_strobe), 16'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", m_write_addr, mon_e.addr);
          chk("wr_data", m_write_data, mon_e.data);
        end
      end else run_len = 0;
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic reg_wr(input logic [1:0] off, input logic [15:0] d);
    write_addr = BASE + {14'd0, off};
    write_data = d;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    write_addr = '0;
    write_data = '0;
  endtask

  task automatic reg_rd(input logic [1:0] off, output logic [15:0] d);
    read_addr = BASE + {14'd0, off};
    tick();
    d = read_data;
    read_addr = '0;
  endtask

  task automatic start_copy(input logic [15:0] s, input logic [15:0] t, input logic [15:0] n);
    reg_wr(2'd0, s);
    reg_wr(2'd1, t);
    reg_wr(2'd2, n);
    for (int i = 0; i < int'(n); i++)
      exp_q.push_back('{addr: t + 16'(i), data: pat(s + 16'(i))});
    wr_cnt = 0; max_run = 0; gap_strobes = 0; rd_after_abort = 0; req_seen = 1'b0;
    reg_wr(2'd3, 16'h0001);
  endtask

  task automatic wait_run();
    for (int i = 0; i < 50 && !(o_bus_req && i_bus_grant); i++) tick();
    chk("run_reached", 16'(o_bus_req && i_bus_grant), 16'd1);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
    repeat (3) tick();
    chk("done_pulses", 16'(done_cnt - d0), 16'd1);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_m_read_addr"}, m_read_addr, 16'd0);
    chk({p, "_m_write_addr"}, m_write_addr, 16'd0);
    chk({p, "_m_write_data"}, m_write_data, 16'd0);
    chk({p, "_ctl_outs"}, {13'd0, m_write_strobe, o_bus_req, o_done}, 16'd0);
    chk({p, "_read_data"}, read_data, 16'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    int d0;
    i_rst = 1'b1;
    read_addr = '0; write_addr = '0; write_data = '0; write_strobe = 1'b0;
    repeat (3) tick();
    chk_zero("rst");
    i_rst = 1'b0;
    tick();
    reg_rd(2'd3, d); chk("rst_status", d, 16'h0000);
    reg_rd(2'd0, d); chk("rst_src", d, 16'h0000);

    // Basic 4-word copy; a SRC write while busy must be ignored.
    d0 = done_cnt;
    start_copy(16'h0100, 16'h0200, 16'd4);
    wait_run();
    reg_wr(2'd0, 16'hDEAD);
    wait_done(d0);
    chk("t1_wr_cnt", 16'(wr_cnt), 16'd4);
    chk("t1_max_run", 16'(max_run), 16'd4);
    chk("t1_q_empty", 16'(exp_q.size()), 16'd0);
    reg_rd(2'd3, d); chk("t1_status", d, 16'h0002);
    reg_rd(2'd0, d); chk("t1_src_end", d, 16'h0104);

    // Clear, then LEN=0 start.
    reg_wr(2'd3, 16'h0004);
    reg_rd(2'd3, d); chk("t2_cleared", d, 16'h0000);
    reg_wr(2'd2, 16'd0);
    req_seen = 1'b0;
    d0 = done_cnt;
    reg_wr(2'd3, 16'h0001);
    chk("t2_done_next", 16'(o_done), 16'd1);
    tick();
    chk("t2_done_pulse", 16'(o_done), 16'd0);
    reg_rd(2'd3, d); chk("t2_status", d, 16'h0002);
    chk("t2_no_req", 16'(req_seen), 16'd0);
    chk("t2_done_cnt", 16'(done_cnt - d0), 16'd1);

    // Address wrap FFFF -> 0000.
    d0 = done_cnt;
    start_copy(16'hFFFE, 16'h0010, 16'd3);
    wait_done(d0);
    chk("t3_wr_cnt", 16'(wr_cnt), 16'd3);
    chk("t3_q_empty", 16'(exp_q.size()), 16'd0);
    reg_rd(2'd0, d); chk("t3_src_end", d, 16'h0001);
    reg_rd(2'd1, d); chk("t3_dst_end", d, 16'h0013);

    // Abort two cycles into RUN.
    d0 = done_cnt;
    start_copy(16'h0300, 16'h0400, 16'd8);
    wait_run();
    tick();
    tick();
    abort_flag = 1'b1;
    reg_wr(2'd3, 16'h0002);
    wait_done(d0);
    chk("t4_wr_2or3", 16'(wr_cnt == 2 || wr_cnt == 3), 16'd1);
    chk("t4_no_rd_after_abort", 16'(rd_after_abort), 16'd0);
    reg_rd(2'd3, d); chk("t4_status", d, 16'h0006);
    chk("t4_req_low", 16'(o_bus_req), 16'd0);
    abort_flag = 1'b0;
    exp_q.delete();

    // Grant withdrawn for 3 cycles mid-RUN.
    d0 = done_cnt;
    start_copy(16'h0500, 16'h0600, 16'd6);
    wait_run();
    tick();
    gnt_hold = 1'b1;
    repeat (3) tick();
    gnt_hold = 1'b0;
    wait_done(d0);
    chk("t5_gap_strobes", 16'(gap_strobes), 16'd0);
    chk("t5_wr_cnt", 16'(wr_cnt), 16'd6);
    chk("t5_q_empty", 16'(exp_q.size()), 16'd0);
    reg_rd(2'd1, d); chk("t5_dst_end", d, 16'h0606);
    reg_rd(2'd3, d); chk("t5_status", d, 16'h0002);

    // Reset in the middle of RUN.
    start_copy(16'h0700, 16'h0800, 16'd8);
    wait_run();
    tick();
    d0 = done_cnt;
    i_rst = 1'b1;
    #1;
    chk_zero("midrst");
    tick();
    i_rst = 1'b0;
    repeat (5) tick();
    chk("t6_no_done", 16'(done_cnt - d0), 16'd0);
    chk("t6_req_low", 16'(o_bus_req), 16'd0);
    reg_rd(2'd3, d); chk("t6_status", d, 16'h0000);
    reg_rd(2'd0, d); chk("t6_src", d, 16'h0000);
    exp_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
